// File: rtl/div_pkg.sv
// div_pkg: shared FSM state type and cycle/counter sizing helpers for div_seq.
package div_pkg;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    // Number of CALC cycles needed to retire all WIDTH quotient bits.
    function automatic int calc_cycles(input int width, input int steps);
        return width / steps;
    endfunction

    // Step counter width, large enough to hold the cycle count.
    function automatic int cnt_width(input int width, input int steps);
        return $clog2(width / steps + 1);
    endfunction

endpackage

// File: rtl/div_step.sv
// div_step: one combinational restoring-division stage (shift in a dividend bit, trial subtract).
module div_step #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH:0]   p,
    input  logic             a_bit,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH:0]   p_next,
    output logic             q_bit
);

    logic [WIDTH+1:0] shifted;
    logic [WIDTH+1:0] trial;

    // The extra top bit of the trial difference is the borrow: set means P < B, so P is restored.
    always_comb begin
        shifted = {p, a_bit};
        trial   = shifted - {2'b00, b};
        q_bit   = ~trial[WIDTH+1];
        p_next  = q_bit ? trial[WIDTH:0] : shifted[WIDTH:0];
    end

endmodule

// File: rtl/div_seq.sv
// div_seq: multi-cycle restoring divider with valid/ready handshakes, STEPS stages per clock.
// Define DIV_SIGNED_EN for two's-complement operands (truncating quotient, remainder signed like dividend).
module div_seq
    import div_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int STEPS = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             rem_nz,
    output logic             div_zero
);

    localparam int CYC = calc_cycles(WIDTH, STEPS);
    localparam int CW  = cnt_width(WIDTH, STEPS);

    state_t           state, state_next;
    logic [WIDTH-1:0] a, b;
    logic [WIDTH:0]   p;
    logic [CW-1:0]    cnt;
    logic             last;
    logic [WIDTH-1:0] a_in, b_in, q_res, r_res;
    logic [WIDTH:0]   p_c [STEPS+1];
    logic [WIDTH-1:0] a_c [STEPS+1];
    logic [STEPS-1:0] q_c;

    assign last = (cnt == CW'(CYC - 1));

    // The dividend register doubles as the quotient: each stage shifts a dividend bit out and a quotient bit in.
    assign p_c[0] = p;
    assign a_c[0] = a;
    for (genvar s = 0; s < STEPS; s++) begin : g_step
        div_step #(.WIDTH(WIDTH)) u_step (
            .p      (p_c[s]),
            .a_bit  (a_c[s][WIDTH-1]),
            .b      (b),
            .p_next (p_c[s+1]),
            .q_bit  (q_c[s])
        );
        assign a_c[s+1] = {a_c[s][WIDTH-2:0], q_c[s]};
    end

`ifdef DIV_SIGNED_EN
    logic neg_q, neg_r;

    // Operands become magnitudes on entry; the result signs are restored when the result is registered.
    always_comb begin
        a_in  = dividend[WIDTH-1] ? -dividend : dividend;
        b_in  = divisor[WIDTH-1] ? -divisor : divisor;
        q_res = neg_q ? -a_c[STEPS] : a_c[STEPS];
        r_res = neg_r ? -p_c[STEPS][WIDTH-1:0] : p_c[STEPS][WIDTH-1:0];
    end

    // Remember the result signs of the accepted operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            neg_q <= 1'b0;
            neg_r <= 1'b0;
        end else if (state == IDLE && in_valid) begin
            neg_q <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
            neg_r <= dividend[WIDTH-1];
        end
    end
`else
    // Unsigned operation feeds the core directly.
    always_comb begin
        a_in  = dividend;
        b_in  = divisor;
        q_res = a_c[STEPS];
        r_res = p_c[STEPS][WIDTH-1:0];
    end
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // Next state and handshake outputs; a zero divisor skips CALC entirely.
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_next = (divisor == '0) ? DONE : CALC;
            end
            CALC: if (last) state_next = DONE;
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Datapath: load on acceptance, iterate in CALC, and update the visible result only on entry to DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a         <= '0;
            b         <= '0;
            p         <= '0;
            cnt       <= '0;
            quotient  <= '0;
            remainder <= '0;
            rem_nz    <= 1'b0;
            div_zero  <= 1'b0;
        end else if (state == IDLE && in_valid) begin
            a   <= a_in;
            b   <= b_in;
            p   <= '0;
            cnt <= '0;
            if (divisor == '0) begin
                quotient  <= '0;
                remainder <= '0;
                rem_nz    <= 1'b0;
                div_zero  <= 1'b1;
            end
        end else if (state == CALC) begin
            a   <= a_c[STEPS];
            p   <= p_c[STEPS];
            cnt <= cnt + 1'b1;
            if (last) begin
                quotient  <= q_res;
                remainder <= r_res;
                rem_nz    <= |p_c[STEPS];
                div_zero  <= 1'b0;
            end
        end
    end

endmodule
